rc5_engine: RTL and testbench

- Parametrised RC5-W/R block cipher core; one module does both encryption and decryption, selected per operation.
- Multi-cycle datapath: one key-table fetch plus two half-round steps per round.
- Sits beside the expanded-key table (synchronous 2-read-port RAM, filled by the key-expansion block). Driven by the cipher controller via a start/done handshake.

---
 rtl/rc5_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_rc5_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_engine.sv
// rc5_engine: RC5-W/R block cipher core, encrypt and decrypt in one datapath.
//
// Each round takes three cycles: FETCH (wait for the key RAM), HALF1 and HALF2.
// Encryption whitens first and decryption whitens last. Either way a full
// operation is 3R+3 cycles from the accept edge to the oDone cycle.
//
// Optional build macro: RC5_ABORT_EN adds the iAbort input. Asserting iAbort
// in any non-IDLE state cancels the operation and no oDone follows.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   iStart       start request (sampled in IDLE only)
//   iAbort       cancel request (RC5_ABORT_EN builds only)
//   iMode        0 = encrypt, 1 = decrypt (captured with iStart)
//   iA, iB       input words (captured with iStart)
//   oS_address1  key-table read address, even index
//   oS_address2  key-table read address, odd index
//   iS_sub_i1    S[oS_address1], valid the cycle after the address register
//   iS_sub_i2    S[oS_address2], same timing
//   oA, oB       result words, held until the next completion
//   oBusy        high in every state except IDLE
//   oDone        one-cycle pulse while the result is first valid
module rc5_engine #(
   parameter int W         = 32,
   parameter int R         = 12,
   parameter int T_LENGTH  = $clog2(2*R+2),
   parameter int ROT_VALUE = $clog2(W),
   parameter int R_BIT     = $clog2(R+1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iStart,
`ifdef RC5_ABORT_EN
   input  logic                iAbort,
`endif
   input  logic                iMode,
   input  logic [W-1:0]        iA,
   input  logic [W-1:0]        iB,
   output logic [T_LENGTH-1:0] oS_address1,
   output logic [T_LENGTH-1:0] oS_address2,
   input  logic [W-1:0]        iS_sub_i1,
   input  logic [W-1:0]        iS_sub_i2,
   output logic [W-1:0]        oA,
   output logic [W-1:0]        oB,
   output logic                oBusy,
   output logic                oDone
);

   typedef enum logic [2:0] {IDLE, FETCH, WHITEN, HALF1, HALF2, DONE} state_t;

   state_t              state_q, state_d;
   logic [W-1:0]        a_q, a_d, b_q, b_d;
   logic                mode_q, mode_d;
   logic                first_q, first_d;
   logic [R_BIT-1:0]    cnt_q, cnt_d, cnt_inc, cnt_dec;
   logic [T_LENGTH-1:0] addr1_d, addr2_d;
   logic [W-1:0]        res_a_d, res_b_d;
   logic                done_d, busy_d;
   logic                abort;

`ifdef RC5_ABORT_EN
   assign abort = iAbort & (state_q != IDLE);
`else
   assign abort = 1'b0;
`endif

   // Rotations are done on a doubled word so an amount of 0 needs no special case.
   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROT_VALUE-1:0] s);
      logic [2*W-1:0] d;
      d = {x, x} << s;
      return d[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [ROT_VALUE-1:0] s);
      logic [2*W-1:0] d;
      d = {x, x} >> s;
      return d[W-1:0];
   endfunction

   // Key-table index of round cnt: 2*cnt (+1 for the odd word).
   function automatic logic [T_LENGTH-1:0] addr_of(input logic [R_BIT-1:0] cnt, input logic odd);
      return T_LENGTH'({cnt, odd});
   endfunction

   assign cnt_inc = cnt_q + R_BIT'(1);
   assign cnt_dec = cnt_q - R_BIT'(1);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (iStart) state_d = FETCH;
         FETCH:   state_d = ((!mode_q && first_q) || (mode_q && (cnt_q == '0))) ? WHITEN : HALF1;
         WHITEN:  state_d = mode_q ? DONE : FETCH;
         HALF1:   state_d = HALF2;
         HALF2:   state_d = (!mode_q && (cnt_q == R_BIT'(R))) ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // Datapath and registered-output next values
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      first_d = first_q;
      cnt_d   = cnt_q;
      addr1_d = oS_address1;
      addr2_d = oS_address2;
      unique case (state_q)
         IDLE: begin
            if (iStart) begin
               a_d     = iA;
               b_d     = iB;
               mode_d  = iMode;
               first_d = 1'b1;
               if (iMode) begin
                  cnt_d   = R_BIT'(R);
                  addr1_d = addr_of(R_BIT'(R), 1'b0);
                  addr2_d = addr_of(R_BIT'(R), 1'b1);
               end else begin
                  cnt_d   = R_BIT'(1);
                  addr1_d = '0;
                  addr2_d = T_LENGTH'(1);
               end
            end
         end
         WHITEN: begin
            first_d = 1'b0;
            if (mode_q) begin
               a_d = a_q - iS_sub_i1;
               b_d = b_q - iS_sub_i2;
            end else begin
               a_d     = a_q + iS_sub_i1;
               b_d     = b_q + iS_sub_i2;
               addr1_d = addr_of(R_BIT'(1), 1'b0);
               addr2_d = addr_of(R_BIT'(1), 1'b1);
            end
         end
         HALF1: begin
            if (mode_q) b_d = rotr(b_q - iS_sub_i2, a_q[ROT_VALUE-1:0]) ^ a_q;
            else        a_d = rotl(a_q ^ b_q, b_q[ROT_VALUE-1:0]) + iS_sub_i1;
         end
         HALF2: begin
            if (mode_q) begin
               a_d     = rotr(a_q - iS_sub_i1, b_q[ROT_VALUE-1:0]) ^ b_q;
               cnt_d   = cnt_dec;
               addr1_d = addr_of(cnt_dec, 1'b0);
               addr2_d = addr_of(cnt_dec, 1'b1);
            end else begin
               b_d = rotl(b_q ^ a_q, a_q[ROT_VALUE-1:0]) + iS_sub_i2;
               if (cnt_q != R_BIT'(R)) begin
                  cnt_d   = cnt_inc;
                  addr1_d = addr_of(cnt_inc, 1'b0);
                  addr2_d = addr_of(cnt_inc, 1'b1);
               end
            end
         end
         default: ;
      endcase
      if (abort) begin
         a_d     = '0;
         b_d     = '0;
         mode_d  = 1'b0;
         first_d = 1'b0;
         cnt_d   = '0;
         addr1_d = '0;
         addr2_d = '0;
      end
   end

   // Outputs are registered from the next state so that oDone, oA and oB are
   // valid during the DONE cycle itself.
   always_comb begin
      done_d  = (state_d == DONE);
      busy_d  = (state_d != IDLE);
      res_a_d = done_d ? a_d : oA;
      res_b_d = done_d ? b_d : oB;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= 1'b0;
         first_q     <= 1'b0;
         cnt_q       <= '0;
         oS_address1 <= '0;
         oS_address2 <= '0;
         oA          <= '0;
         oB          <= '0;
         oDone       <= 1'b0;
         oBusy       <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         mode_q      <= mode_d;
         first_q     <= first_d;
         cnt_q       <= cnt_d;
         oS_address1 <= addr1_d;
         oS_address2 <= addr2_d;
         oA          <= res_a_d;
         oB          <= res_b_d;
         oDone       <= done_d;
         oBusy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_rc5_engine.sv
// tb_rc5_engine: directed, table-driven bench for rc5_engine.
// DUT u32: W=32, R=12 with a zero-key expanded table in a synchronous RAM model.
// DUT u16: W=16, R=1 with an all-zero table.
module tb_rc5_engine;

   logic clk;
   logic rst;

   logic        start32, mode32;
   logic [31:0] a32, b32, s1_32, s2_32, oa32, ob32;
   logic [4:0]  addr1_32, addr2_32;
   logic        busy32, done32;

   logic        start16, mode16;
   logic [15:0] a16, b16, zero16, oa16, ob16;
   logic [1:0]  addr1_16, addr2_16;
   logic        busy16, done16;

`ifdef RC5_ABORT_EN
   logic        abort32, abort16;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] ktab [0:25];
   logic [9:0]  addr_log [$];

   rc5_engine #(.W(32), .R(12)) u32 (
      .clk(clk), .rst(rst), .iStart(start32),
`ifdef RC5_ABORT_EN
      .iAbort(abort32),
`endif
      .iMode(mode32), .iA(a32), .iB(b32),
      .oS_address1(addr1_32), .oS_address2(addr2_32),
      .iS_sub_i1(s1_32), .iS_sub_i2(s2_32),
      .oA(oa32), .oB(ob32), .oBusy(busy32), .oDone(done32)
   );

   rc5_engine #(.W(16), .R(1)) u16 (
      .clk(clk), .rst(rst), .iStart(start16),
`ifdef RC5_ABORT_EN
      .iAbort(abort16),
`endif
      .iMode(mode16), .iA(a16), .iB(b16),
      .oS_address1(addr1_16), .oS_address2(addr2_16),
      .iS_sub_i1(zero16), .iS_sub_i2(zero16),
      .oA(oa16), .oB(ob16), .oBusy(busy16), .oDone(done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous two-port key RAM
   always @(posedge clk) begin
      s1_32 <= ktab[addr1_32];
      s2_32 <= ktab[addr2_32];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
      return (x << s) | (x >> (32 - int'(s)));
   endfunction

   function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] s);
      return (x >> s) | (x << (32 - int'(s)));
   endfunction

   function automatic logic [63:0] ref_enc(input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] a, b;
      a = a_in + ktab[0];
      b = b_in + ktab[1];
      for (int i = 1; i <= 12; i++) begin
         a = rotl32(a ^ b, b[4:0]) + ktab[2*i];
         b = rotl32(b ^ a, a[4:0]) + ktab[2*i+1];
      end
      return {a, b};
   endfunction

   function automatic logic [63:0] ref_dec(input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] a, b;
      a = a_in;
      b = b_in;
      for (int i = 12; i >= 1; i--) begin
         b = rotr32(b - ktab[2*i+1], a[4:0]) ^ a;
         a = rotr32(a - ktab[2*i], b[4:0]) ^ b;
      end
      return {a - ktab[0], b - ktab[1]};
   endfunction

   function automatic bit addr_seq_ok(input logic mode);
      logic [4:0] e1, e2;
      int k;
      if (addr_log.size() != 13) return 1'b0;
      for (int i = 0; i < 13; i++) begin
         k  = mode ? 12 - i : i;
         e1 = 5'(2*k);
         e2 = 5'(2*k+1);
         if (addr_log[i] != {e1, e2}) return 1'b0;
      end
      return 1'b1;
   endfunction

   // One u32 operation; optional extra iStart pulses at cycles inj1/inj2
   // (cycle n = the cycle whose inputs are sampled at edge n after the start edge).
   task automatic run32(input logic mode, input logic [31:0] a, input logic [31:0] b,
                        input int inj1, input int inj2,
                        output logic [31:0] ra, output logic [31:0] rb,
                        output int lat, output int busy_n);
      lat    = -1;
      busy_n = 0;
      ra     = '0;
      rb     = '0;
      addr_log.delete();
      @(negedge clk);
      mode32  = mode;
      a32     = a;
      b32     = b;
      start32 = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (cyc == inj1 || cyc == inj2) begin
            start32 = 1'b1;
            a32     = 32'hDEADBEEF;
            b32     = 32'h0BADF00D;
            mode32  = ~mode;
         end else begin
            start32 = 1'b0;
         end
         if (busy32) busy_n++;
         if (addr_log.size() == 0 || addr_log[addr_log.size()-1] != {addr1_32, addr2_32})
            addr_log.push_back({addr1_32, addr2_32});
         if (done32) begin
            lat = cyc;
            ra  = oa32;
            rb  = ob32;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      start32 = 1'b0;
      check("done_single_pulse", {63'd0, done32}, 64'd0);
      check("idle_after_done", {63'd0, busy32}, 64'd0);
   endtask

   task automatic run16(input logic mode, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] ra, output logic [15:0] rb, output int lat);
      lat = -1;
      ra  = '0;
      rb  = '0;
      @(negedge clk);
      mode16  = mode;
      a16     = a;
      b16     = b;
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      for (int cyc = 1; cyc <= 50; cyc++) begin
         if (done16) begin
            lat = cyc;
            ra  = oa16;
            rb  = ob16;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        mode;
      logic [31:0] a, b, ea, eb;
   } vec_t;

   initial begin
      vec_t        vecs [7];
      logic [31:0] lk [0:3];
      logic [31:0] ka, kb, tmp;
      logic [63:0] m;
      logic [31:0] ra, rb;
      logic [15:0] ra16, rb16;
      int          ii, jj, lat, busy_n;
      bit          quiet;

      rst = 1'b1; start32 = 1'b0; mode32 = 1'b0; a32 = '0; b32 = '0;
      start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0; zero16 = '0;
`ifdef RC5_ABORT_EN
      abort32 = 1'b0; abort16 = 1'b0;
`endif

      // Zero-key (16 bytes) RC5-32/12 key expansion
      for (int i = 0; i < 4; i++) lk[i] = '0;
      ktab[0] = 32'hB7E15163;
      for (int i = 1; i < 26; i++) ktab[i] = ktab[i-1] + 32'h9E3779B9;
      ka = '0; kb = '0; ii = 0; jj = 0;
      for (int k = 0; k < 78; k++) begin
         ka       = rotl32(ktab[ii] + ka + kb, 5'd3);
         ktab[ii] = ka;
         tmp      = ka + kb;
         kb       = rotl32(lk[jj] + tmp, tmp[4:0]);
         lk[jj]   = kb;
         ii       = (ii + 1) % 26;
         jj       = (jj + 1) % 4;
      end

      vecs[0] = '{1'b0, 32'h00000000, 32'h00000000, 32'hEEDBA521, 32'h6D8F4B15};
      vecs[1] = '{1'b1, 32'hEEDBA521, 32'h6D8F4B15, 32'h00000000, 32'h00000000};
      m = ref_enc(32'hFFFFFFFF, 32'hFFFFFFFF);
      vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, m[63:32], m[31:0]};
      vecs[3] = '{1'b1, m[63:32], m[31:0], 32'hFFFFFFFF, 32'hFFFFFFFF};
      m = ref_enc(32'h12345678, 32'h9ABCDEF0);
      vecs[4] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, m[63:32], m[31:0]};
      m = ref_dec(32'h12345678, 32'h9ABCDEF0);
      vecs[5] = '{1'b1, 32'h12345678, 32'h9ABCDEF0, m[63:32], m[31:0]};
      m = ref_enc(32'h80000000, 32'h00000001);
      vecs[6] = '{1'b0, 32'h80000000, 32'h00000001, m[63:32], m[31:0]};

      // Reset state
      #2 rst = 1'b0;
      #1;
      check("reset_oA", {32'd0, oa32}, 64'd0);
      check("reset_oB", {32'd0, ob32}, 64'd0);
      check("reset_addr", {54'd0, addr1_32, addr2_32}, 64'd0);
      check("reset_done_busy", {62'd0, done32, busy32}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         run32(vecs[i].mode, vecs[i].a, vecs[i].b, 0, 0, ra, rb, lat, busy_n);
         check($sformatf("v%0d_oA", i), {32'd0, ra}, {32'd0, vecs[i].ea});
         check($sformatf("v%0d_oB", i), {32'd0, rb}, {32'd0, vecs[i].eb});
         check($sformatf("v%0d_latency", i), 64'(lat), 64'd39);
         check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'd39);
         check($sformatf("v%0d_addr_seq", i), {63'd0, addr_seq_ok(vecs[i].mode)}, 64'd1);
      end

      // Starts at cycle 5 (busy) and 39 (DONE) are ignored; cycle 40 is accepted
      run32(1'b0, 32'h0, 32'h0, 5, 39, ra, rb, lat, busy_n);
      check("ign_oA", {32'd0, ra}, {32'd0, 32'hEEDBA521});
      check("ign_oB", {32'd0, rb}, {32'd0, 32'h6D8F4B15});
      check("ign_latency", 64'(lat), 64'd39);
      run32(vecs[2].mode, vecs[2].a, vecs[2].b, 0, 0, ra, rb, lat, busy_n);
      check("b2b_oA", {32'd0, ra}, {32'd0, vecs[2].ea});
      check("b2b_oB", {32'd0, rb}, {32'd0, vecs[2].eb});
      check("b2b_latency", 64'(lat), 64'd39);

      // Asynchronous reset in cycle 10 of an operation
      @(negedge clk);
      mode32 = 1'b0; a32 = 32'h0; b32 = 32'h0; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_oA_oB", {oa32, ob32}, 64'd0);
      check("midrst_addr", {54'd0, addr1_32, addr2_32}, 64'd0);
      check("midrst_done_busy", {62'd0, done32, busy32}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      quiet = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (done32 || busy32) quiet = 1'b0;
      end
      check("midrst_no_done", {63'd0, quiet}, 64'd1);
      run32(1'b0, 32'h0, 32'h0, 0, 0, ra, rb, lat, busy_n);
      check("postrst_oA", {32'd0, ra}, {32'd0, 32'hEEDBA521});
      check("postrst_oB", {32'd0, rb}, {32'd0, 32'h6D8F4B15});
      check("postrst_latency", 64'(lat), 64'd39);

      // W=16, R=1, zero table: rotations by 15 and 7 exercise the rotate boundary
      run16(1'b0, 16'h0001, 16'h000F, ra16, rb16, lat);
      check("w16_enc_oA", {48'd0, ra16}, 64'h0007);
      check("w16_enc_oB", {48'd0, rb16}, 64'h0400);
      check("w16_enc_latency", 64'(lat), 64'd6);
      run16(1'b1, 16'h0007, 16'h0400, ra16, rb16, lat);
      check("w16_dec_oA", {48'd0, ra16}, 64'h0001);
      check("w16_dec_oB", {48'd0, rb16}, 64'h000F);
      check("w16_dec_latency", 64'(lat), 64'd6);

`ifdef RC5_ABORT_EN
      // Abort at cycle 20; outputs keep the last result (0 -> EEDBA521/6D8F4B15)
      @(negedge clk);
      mode32 = 1'b0; a32 = 32'h12345678; b32 = 32'h9ABCDEF0; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (19) @(posedge clk);
      #1 abort32 = 1'b1;
      @(posedge clk); #1;
      abort32 = 1'b0;
      check("abort_busy_done", {62'd0, busy32, done32}, 64'd0);
      check("abort_hold_oA_oB", {oa32, ob32}, {32'hEEDBA521, 32'h6D8F4B15});
      check("abort_addr", {54'd0, addr1_32, addr2_32}, 64'd0);
      run32(vecs[4].mode, vecs[4].a, vecs[4].b, 0, 0, ra, rb, lat, busy_n);
      check("post_abort_oA", {32'd0, ra}, {32'd0, vecs[4].ea});
      check("post_abort_oB", {32'd0, rb}, {32'd0, vecs[4].eb});
      check("post_abort_latency", 64'(lat), 64'd39);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
